mips_dmem_router: RTL and testbench

Data-side bus router for the single-cycle MIPS core. It sits between the core's load/store port and two memory targets: data RAM (target A) and the MMIO peripheral window (target B). It accepts one request at a time over a valid/ready handshake and decodes the address to steer the request to exactly one target. It then waits for that target's read data and returns a single response pulse to the core.

---
 rtl/mips_bus_pkg.sv | 16 +
 rtl/mips_dmem_router_mux2x1.sv | 15 +
 rtl/mips_dmem_router.sv | 135 +++++++++++++
 tb/tb_mips_dmem_router.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS data-side bus router.
// Contents: router state encoding and the default MMIO window (base/mask).
// Imported by mips_dmem_router and its read-data mux.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } router_state_t;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_MASK_DEFAULT = 32'hFFFF_0000;

endpackage

// File: rtl/mips_dmem_router_mux2x1.sv
// Two-input read-data selector placed ahead of the router's capture register.
// Ports: Sel (0 = In0 / target A, 1 = In1 / target B), In0, In1, Out.
// Purely combinational.
module MUX2X1Module #(
  parameter int WIDTH = 32
) (
  input  logic             Sel,
  input  logic [WIDTH-1:0] In0,
  input  logic [WIDTH-1:0] In1,
  output logic [WIDTH-1:0] Out
);

  assign Out = Sel ? In1 : In0;

endmodule

// File: rtl/mips_dmem_router.sv
// Data-side router: steers one core load/store at a time to data RAM (A) or the MMIO window (B).
// Ports: Clk/Rst; core request (Req_*) and one-cycle response (Rsp_*);
//        per-target request (X_Valid/Ready/Addr/WData/WE) and read return (X_RspValid/RData).
module mips_dmem_router
  import mips_bus_pkg::*;
#(
  parameter int                    WIDTH      = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = ADDR_WIDTH'(MMIO_BASE_DEFAULT),
  parameter logic [ADDR_WIDTH-1:0] MMIO_MASK  = ADDR_WIDTH'(MMIO_MASK_DEFAULT)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  // core side
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic [ADDR_WIDTH-1:0] Req_Addr,
  input  logic [WIDTH-1:0]      Req_WData,
  input  logic                  Req_WE,
  output logic                  Rsp_Valid,
  output logic [WIDTH-1:0]      Rsp_RData,
  // target A (data RAM)
  output logic                  A_Valid,
  input  logic                  A_Ready,
  output logic [ADDR_WIDTH-1:0] A_Addr,
  output logic [WIDTH-1:0]      A_WData,
  output logic                  A_WE,
  input  logic                  A_RspValid,
  input  logic [WIDTH-1:0]      A_RData,
  // target B (MMIO window)
  output logic                  B_Valid,
  input  logic                  B_Ready,
  output logic [ADDR_WIDTH-1:0] B_Addr,
  output logic [WIDTH-1:0]      B_WData,
  output logic                  B_WE,
  input  logic                  B_RspValid,
  input  logic [WIDTH-1:0]      B_RData
);

  router_state_t         state;
  router_state_t         state_next;

  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0]      lat_wdata;
  logic                  lat_we;
  logic                  lat_sel;
  logic [WIDTH-1:0]      rsp_rdata;

  logic                  req_sel;
  logic                  accept;
  logic                  tgt_ready;
  logic                  tgt_rsp_valid;
  logic [WIDTH-1:0]      tgt_rdata;

  assign req_sel = ((Req_Addr & MMIO_MASK) == MMIO_BASE);

  // Ready is gated by Rst as well so the core never sees a handshake while
  // the router is being held in reset.
  assign Req_Ready = (state == IDLE) && !Rst;
  assign accept    = Req_Valid && Req_Ready;

  // Only the target chosen at acceptance time is listened to; the other
  // target's handshake and read-return lines are don't-cares.
  assign tgt_ready     = lat_sel ? B_Ready    : A_Ready;
  assign tgt_rsp_valid = lat_sel ? B_RspValid : A_RspValid;

  MUX2X1Module #(
    .WIDTH (WIDTH)
  ) u_rdata_mux (
    .Sel (lat_sel),
    .In0 (A_RData),
    .In1 (B_RData),
    .Out (tgt_rdata)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)        state_next = ISSUE;
      ISSUE:   if (tgt_ready)     state_next = lat_we ? DONE : WAIT;
      WAIT:    if (tgt_rsp_valid) state_next = DONE;
      DONE:                       state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_sel   <= 1'b0;
    end else if (accept) begin
      lat_addr  <= Req_Addr;
      lat_wdata <= Req_WData;
      lat_we    <= Req_WE;
      lat_sel   <= req_sel;
    end
  end

  // Load data is captured only in WAIT; a completed store clears it so the
  // store's response carries zero. Otherwise the last load result is held.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rsp_rdata <= '0;
    end else if ((state == WAIT) && tgt_rsp_valid) begin
      rsp_rdata <= tgt_rdata;
    end else if ((state == ISSUE) && tgt_ready && lat_we) begin
      rsp_rdata <= '0;
    end
  end

  // Valids decode straight from the state register, so reset drops them
  // asynchronously without waiting for a clock edge.
  assign A_Valid   = (state == ISSUE) && !lat_sel;
  assign B_Valid   = (state == ISSUE) &&  lat_sel;
  assign Rsp_Valid = (state == DONE);
  assign Rsp_RData = rsp_rdata;

  assign A_Addr  = lat_addr;
  assign A_WData = lat_wdata;
  assign A_WE    = lat_we;
  assign B_Addr  = lat_addr;
  assign B_WData = lat_wdata;
  assign B_WE    = lat_we;

endmodule

// File: tb/tb_mips_dmem_router.sv
// Bench for mips_dmem_router: directed cases followed by randomized loads/stores
// with random target stalls and stray response noise, checked against a
// transaction-level expectation computed in the bench.
module tb_mips_dmem_router;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req_Valid;
  logic        Req_Ready;
  logic [31:0] Req_Addr;
  logic [31:0] Req_WData;
  logic        Req_WE;
  logic        Rsp_Valid;
  logic [31:0] Rsp_RData;
  logic        A_Valid, A_Ready, A_WE, A_RspValid;
  logic [31:0] A_Addr, A_WData, A_RData;
  logic        B_Valid, B_Ready, B_WE, B_RspValid;
  logic [31:0] B_Addr, B_WData, B_RData;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_rdata;

  always #5 Clk = ~Clk;

  mips_dmem_router dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Req_Valid  (Req_Valid),
    .Req_Ready  (Req_Ready),
    .Req_Addr   (Req_Addr),
    .Req_WData  (Req_WData),
    .Req_WE     (Req_WE),
    .Rsp_Valid  (Rsp_Valid),
    .Rsp_RData  (Rsp_RData),
    .A_Valid    (A_Valid),
    .A_Ready    (A_Ready),
    .A_Addr     (A_Addr),
    .A_WData    (A_WData),
    .A_WE       (A_WE),
    .A_RspValid (A_RspValid),
    .A_RData    (A_RData),
    .B_Valid    (B_Valid),
    .B_Ready    (B_Ready),
    .B_Addr     (B_Addr),
    .B_WData    (B_WData),
    .B_WE       (B_WE),
    .B_RspValid (B_RspValid),
    .B_RData    (B_RData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one target's inputs; b selects which target.
  task automatic drive(input bit b, input bit rdy, input bit rv, input logic [31:0] rd);
    if (b) begin
      B_Ready = rdy; B_RspValid = rv; B_RData = rd;
    end else begin
      A_Ready = rdy; A_RspValid = rv; A_RData = rd;
    end
  endtask

  task automatic idle_targets();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  // One full transaction. Called right after a negedge is due; returns with the
  // bench sitting at the negedge of the DONE cycle.
  // rs: cycles the selected Ready is held low; ws: cycles after the handshake
  // before RspValid; noise: stray RspValid from the wrong target / wrong state.
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input bit we,
                        input int rs, input int ws, input bit noise,
                        input logic [31:0] rdata);
    bit sel;
    sel = (addr >= 32'hFFFF_0000);   // MMIO window is the top 64 KiB
    @(negedge Clk);
    chk("idle_ready", 32'(Req_Ready), 32'd1);
    chk("idle_rsp_valid", 32'(Rsp_Valid), 32'd0);
    chk("idle_rdata_hold", Rsp_RData, exp_rdata);
    Req_Valid = 1'b1; Req_Addr = addr; Req_WData = wdata; Req_WE = we;
    @(negedge Clk);
    // accepted; scramble the request lines, they must not matter any more
    Req_Valid = $urandom_range(0, 1); Req_Addr = $urandom; Req_WData = $urandom;
    Req_WE = $urandom_range(0, 1);
    for (int i = 0; i <= rs; i++) begin
      chk("issue_a_valid", 32'(A_Valid), 32'(!sel));
      chk("issue_b_valid", 32'(B_Valid), 32'(sel));
      chk("issue_req_ready", 32'(Req_Ready), 32'd0);
      chk("issue_rsp_valid", 32'(Rsp_Valid), 32'd0);
      chk("issue_a_addr", A_Addr, addr);
      chk("issue_b_addr", B_Addr, addr);
      chk("issue_wdata", sel ? B_WData : A_WData, wdata);
      chk("issue_we", 32'(sel ? B_WE : A_WE), 32'(we));
      drive(sel, i == rs, noise && (i < rs), $urandom);
      drive(!sel, 1'b0, noise, 32'h0000_0BAD);
      @(negedge Clk);
    end
    idle_targets();
    if (!we) begin
      for (int j = 0; j <= ws; j++) begin
        chk("wait_rsp_valid", 32'(Rsp_Valid), 32'd0);
        chk("wait_valids", 32'({A_Valid, B_Valid}), 32'd0);
        chk("wait_req_ready", 32'(Req_Ready), 32'd0);
        drive(sel, 1'b0, j == ws, (j == ws) ? rdata : $urandom);
        drive(!sel, 1'b0, noise, 32'h0000_0BAD);
        @(negedge Clk);
      end
      idle_targets();
      exp_rdata = rdata;
    end else begin
      exp_rdata = 32'h0;
    end
    chk("done_rsp_valid", 32'(Rsp_Valid), 32'd1);
    chk("done_rdata", Rsp_RData, exp_rdata);
    chk("done_valids", 32'({A_Valid, B_Valid}), 32'd0);
    Req_Valid = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; Req_Valid = 1'b0; Req_Addr = '0; Req_WData = '0; Req_WE = 1'b0;
    idle_targets();
    exp_rdata = 32'h0;
    repeat (2) @(negedge Clk);
    chk("rst_req_ready", 32'(Req_Ready), 32'd0);
    chk("rst_valids", 32'({A_Valid, B_Valid}), 32'd0);
    chk("rst_rsp_valid", 32'(Rsp_Valid), 32'd0);
    chk("rst_rsp_rdata", Rsp_RData, 32'd0);
    chk("rst_addr", A_Addr, 32'd0);
    chk("rst_wdata", B_WData, 32'd0);
    chk("rst_we", 32'({A_WE, B_WE}), 32'd0);
    Rst = 1'b0;
    #1;
    chk("rel_req_ready", 32'(Req_Ready), 32'd1);

    // directed cases
    do_txn(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 0, 0, 1'b0, 32'h0);   // store to A
    do_txn(32'hFFFF_0004, 32'h0,         1'b0, 0, 0, 1'b0, 32'h1234); // load from B
    do_txn(32'h0000_0020, 32'h0,         1'b0, 3, 1, 1'b0, 32'hCAFE_F00D); // stalled load A
    do_txn(32'h0000_0030, 32'h0,         1'b0, 0, 2, 1'b1, 32'h0000_5A5A); // B noise ignored
    do_txn(32'hFFFF_FFFC, 32'h1111_2222, 1'b1, 2, 0, 1'b1, 32'h0);   // store to top of B
    do_txn(32'hFFFE_FFFC, 32'h0,         1'b0, 0, 0, 1'b1, 32'h7777_0001); // just below window -> A

    // reset while ISSUE: Valid must drop asynchronously
    @(negedge Clk);
    Req_Valid = 1'b1; Req_Addr = 32'h0000_0040; Req_WE = 1'b0;
    @(negedge Clk);
    Req_Valid = 1'b0;
    chk("pre_rst_a_valid", 32'(A_Valid), 32'd1);
    #2 Rst = 1'b1;
    #1;
    chk("rst_issue_a_valid", 32'(A_Valid), 32'd0);
    chk("rst_issue_req_ready", 32'(Req_Ready), 32'd0);
    chk("rst_issue_rdata", Rsp_RData, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    exp_rdata = 32'h0;

    // reset while WAIT: no stale response afterwards
    @(negedge Clk);
    Req_Valid = 1'b1; Req_Addr = 32'h0000_0044; Req_WE = 1'b0;
    @(negedge Clk);
    Req_Valid = 1'b0;
    A_Ready = 1'b1;
    @(negedge Clk);
    A_Ready = 1'b0;
    chk("wait_pre_rst_req_ready", 32'(Req_Ready), 32'd0);
    #2 Rst = 1'b1;
    #1;
    chk("rst_wait_valids", 32'({A_Valid, B_Valid}), 32'd0);
    chk("rst_wait_rsp_valid", 32'(Rsp_Valid), 32'd0);
    chk("rst_wait_req_ready", 32'(Req_Ready), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    A_RspValid = 1'b1; A_RData = 32'hBEEF_0BAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("post_rst_req_ready", 32'(Req_Ready), 32'd1);
      chk("post_rst_no_rsp", 32'(Rsp_Valid), 32'd0);
      chk("post_rst_rdata", Rsp_RData, 32'd0);
    end
    idle_targets();

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      a = $urandom_range(0, 1) ? {16'hFFFF, 16'($urandom)} : $urandom;
      do_txn(a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
             $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom);
    end

    @(negedge Clk);
    chk("final_rsp_single", 32'(Rsp_Valid), 32'd0);
    chk("final_rdata_hold", Rsp_RData, exp_rdata);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
